// File: rtl/alu_bist_pkg.sv
// rtl/alu_bist_pkg.sv - shared types and constants for the ALU BIST sequencer
package alu_bist_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_LSH = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_SUB = 3'd4,
      OP_RSH = 3'd5,
      OP_CMP = 3'd6
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_DRIVE,
      ST_CHECK,
      ST_DONE
   } bist_state_e;

   localparam int NUM_CORNERS = 4;

   // {A,B} per corner vector; entry 0 is applied first
   localparam logic [NUM_CORNERS-1:0][15:0] CORNER_VECS =
      {16'hFFFF, 16'h8080, 16'hFF01, 16'h0000};

   // Fibonacci taps 16,14,13,11
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/alu_bist_if.sv
// rtl/alu_bist_if.sv - ALU operand/result bundle between the BIST initiator and the ALU
interface alu_bist_if;
   import alu_bist_pkg::*;

   logic [7:0] dat_a;
   logic [7:0] dat_b;
   alu_op_e    alu_op;
   logic       sc_in;
   logic [7:0] rslt;
   logic       zero;
   logic       par;
   logic       sco;

   modport master (
      output dat_a, dat_b, alu_op, sc_in,
      input  rslt, zero, par, sco
   );

   modport slave (
      input  dat_a, dat_b, alu_op, sc_in,
      output rslt, zero, par, sco
   );

endinterface

// File: rtl/alu_bist_ref_model.sv
// rtl/alu_bist_ref_model.sv - combinational ALU reference model
// SCo is only meaningful for ADD/LSH/RSH, flagged by o_sco_valid.
module alu_ref_model
   import alu_bist_pkg::*;
(
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  alu_op_e    i_op,
   input  logic       i_sc_in,
   output logic [7:0] o_rslt,
   output logic       o_zero,
   output logic       o_par,
   output logic       o_sco,
   output logic       o_sco_valid
);

   logic [8:0] w_sum;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b};

   always_comb begin
      o_rslt      = 8'h00;
      o_sco       = 1'b0;
      o_sco_valid = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_rslt      = w_sum[7:0];
            o_sco       = w_sum[8];
            o_sco_valid = 1'b1;
         end
         OP_LSH: begin
            o_rslt      = {i_a[6:0], i_sc_in};
            o_sco       = i_a[7];
            o_sco_valid = 1'b1;
         end
         OP_AND: o_rslt = i_a & i_b;
         OP_OR:  o_rslt = i_a | i_b;
         OP_SUB: o_rslt = i_a - i_b;
         OP_RSH: begin
            o_rslt      = {1'b0, i_a[7:1]};
            o_sco       = i_a[0];
            o_sco_valid = 1'b1;
         end
         OP_CMP: o_rslt = {6'b0, (i_a > i_b), (i_a != i_b)};
         default: o_rslt = 8'h00;
      endcase
   end

   assign o_zero = (o_rslt == 8'h00);
   assign o_par  = ^o_rslt;

endmodule

// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - ALU built-in self-test sequencer
// Drives corner then LFSR vectors per opcode and scores the ALU response.
module alu_bist
   import alu_bist_pkg::*;
#(
   parameter int unsigned VECS_PER_OP = 16,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   alu_bist_if.master alu,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [7:0] o_fail_count,
   output logic [2:0] o_fail_op,
   output logic [7:0] o_fail_a,
   output logic [7:0] o_fail_b
);

   localparam logic [8:0] LAST_VEC = 9'(VECS_PER_OP + NUM_CORNERS - 1);

   bist_state_e r_state;
   logic [15:0] r_lfsr;
   alu_op_e     r_op;
   logic [8:0]  r_vec;
   logic [7:0]  r_dat_a;
   logic [7:0]  r_dat_b;
   alu_op_e     r_alu_op;
   logic        r_sc_in;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [7:0]  r_fail_count;
   logic [2:0]  r_fail_op;
   logic [7:0]  r_fail_a;
   logic [7:0]  r_fail_b;

   logic [7:0]  w_exp_rslt;
   logic        w_exp_zero;
   logic        w_exp_par;
   logic        w_exp_sco;
   logic        w_exp_sco_valid;
   logic        w_mismatch;

   alu_ref_model u_ref (
      .i_a         (r_dat_a),
      .i_b         (r_dat_b),
      .i_op        (r_alu_op),
      .i_sc_in     (r_sc_in),
      .o_rslt      (w_exp_rslt),
      .o_zero      (w_exp_zero),
      .o_par       (w_exp_par),
      .o_sco       (w_exp_sco),
      .o_sco_valid (w_exp_sco_valid)
   );

   assign w_mismatch = (alu.rslt != w_exp_rslt) || (alu.zero != w_exp_zero) ||
                       (alu.par != w_exp_par) ||
                       (w_exp_sco_valid && (alu.sco != w_exp_sco));

   // Status outputs trail the state by one cycle, so Done lands 2 + 2*vectors after Start
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_lfsr       <= LFSR_SEED;
         r_op         <= OP_ADD;
         r_vec        <= 9'd0;
         r_dat_a      <= 8'h00;
         r_dat_b      <= 8'h00;
         r_alu_op     <= OP_ADD;
         r_sc_in      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail_count <= 8'h00;
         r_fail_op    <= 3'd0;
         r_fail_a     <= 8'h00;
         r_fail_b     <= 8'h00;
      end else begin
         r_busy <= (r_state == ST_SEED) || (r_state == ST_DRIVE) || (r_state == ST_CHECK);
         r_done <= (r_state == ST_DONE);
         r_pass <= (r_state == ST_DONE) && (r_fail_count == 8'h00);
         case (r_state)
            ST_IDLE: if (i_start) r_state <= ST_SEED;
            ST_SEED: begin
               r_lfsr       <= LFSR_SEED;
               r_fail_count <= 8'h00;
               r_fail_op    <= 3'd0;
               r_fail_a     <= 8'h00;
               r_fail_b     <= 8'h00;
               r_op         <= OP_ADD;
               r_vec        <= 9'd0;
               r_state      <= ST_DRIVE;
            end
            ST_DRIVE: begin
               r_alu_op <= r_op;
               if (r_vec < 9'(NUM_CORNERS)) begin
                  {r_dat_a, r_dat_b} <= CORNER_VECS[r_vec[1:0]];
                  r_sc_in            <= 1'b0;
               end else begin
                  r_dat_a <= r_lfsr[15:8];
                  r_dat_b <= r_lfsr[7:0];
                  r_sc_in <= r_lfsr[0] ^ r_lfsr[15];
               end
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (w_mismatch) begin
                  // a zero count means no earlier failure in this run
                  if (r_fail_count == 8'h00) begin
                     r_fail_op <= r_alu_op;
                     r_fail_a  <= r_dat_a;
                     r_fail_b  <= r_dat_b;
                  end
                  if (r_fail_count != 8'hFF) r_fail_count <= r_fail_count + 8'd1;
               end
               if (r_vec >= 9'(NUM_CORNERS)) r_lfsr <= lfsr_next(r_lfsr);
               if (r_vec == LAST_VEC) begin
                  r_vec <= 9'd0;
                  if (r_op == OP_CMP) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_op    <= alu_op_e'(r_op + 3'd1);
                     r_state <= ST_DRIVE;
                  end
               end else begin
                  r_vec   <= r_vec + 9'd1;
                  r_state <= ST_DRIVE;
               end
            end
            ST_DONE: if (i_start) r_state <= ST_SEED;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign alu.dat_a    = r_dat_a;
   assign alu.dat_b    = r_dat_b;
   assign alu.alu_op   = r_alu_op;
   assign alu.sc_in    = r_sc_in;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_fail_count = r_fail_count;
   assign o_fail_op    = r_fail_op;
   assign o_fail_a     = r_fail_a;
   assign o_fail_b     = r_fail_b;

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - self-checking bench for alu_bist with a fault-injectable ALU
module tb_alu_bist;
   import alu_bist_pkg::*;

   localparam int VPO     = 16;
   localparam int VPO_SAT = 40;

   typedef struct {
      int op;
      int a;
      int b;
      int sc;
   } vec_t;

   typedef struct {
      int start_edge;
      int done_edge;
      int fails;
      int fop;
      int fa;
      int fb;
   } sum_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       start_sat;
   logic       busy, done, pass;
   logic [7:0] fail_count, fail_a, fail_b;
   logic [2:0] fail_op;
   logic       s_busy, s_done, s_pass;
   logic [7:0] s_fail_count, s_fail_a, s_fail_b;
   logic [2:0] s_fail_op;

   int   n_checks = 0;
   int   n_fails  = 0;
   int   cyc      = 0;
   int   fault_mode = 0;

   vec_t exp_vec_q[$];
   sum_t exp_sum_q[$];

   alu_bist_if aif ();
   alu_bist_if sif ();

   alu_bist #(.VECS_PER_OP(VPO), .LFSR_SEED(16'hACE1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .alu(aif),
      .o_busy(busy), .o_done(done), .o_pass(pass), .o_fail_count(fail_count),
      .o_fail_op(fail_op), .o_fail_a(fail_a), .o_fail_b(fail_b)
   );

   alu_bist #(.VECS_PER_OP(VPO_SAT), .LFSR_SEED(16'hACE1)) u_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_sat), .alu(sif),
      .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_fail_count(s_fail_count),
      .o_fail_op(s_fail_op), .o_fail_a(s_fail_a), .o_fail_b(s_fail_b)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // returns {rslt[7:0], zero, par, sco}
   function automatic logic [10:0] golden(input int op, input int a, input int b, input int sc);
      int r;
      int c;
      r = 0;
      c = 0;
      case (op)
         0: begin r = (a + b) % 256; c = (a + b) / 256; end
         1: begin r = (a * 2 + sc) % 256; c = a / 128; end
         2: r = a & b;
         3: r = a | b;
         4: r = (a - b + 256) % 256;
         5: begin r = a / 2; c = a % 2; end
         6: r = (a > b ? 2 : 0) + (a != b ? 1 : 0);
         default: r = 0;
      endcase
      return {r[7:0], (r == 0), (($countones(r[7:0]) % 2) == 1), c[0]};
   endfunction

   // 1 par inverted, 2 AND rslt[0] stuck-0, 3 zero stuck-0, 4 sco inverted, 5 OR rslt[7] stuck-1
   function automatic logic [10:0] faulty(input int op, input int a, input int b, input int sc, input int mode);
      logic [10:0] g;
      g = golden(op, a, b, sc);
      case (mode)
         1: g[1] = ~g[1];
         2: if (op == 2) g[3] = 1'b0;
         3: g[2] = 1'b0;
         4: g[0] = ~g[0];
         5: if (op == 3) g[10] = 1'b1;
         default: ;
      endcase
      return g;
   endfunction

   logic [10:0] w_resp, w_sresp;
   always_comb begin
      w_resp   = faulty(int'(aif.alu_op), int'(aif.dat_a), int'(aif.dat_b), int'(aif.sc_in), fault_mode);
      aif.rslt = w_resp[10:3];
      aif.zero = w_resp[2];
      aif.par  = w_resp[1];
      aif.sco  = w_resp[0];
   end
   always_comb begin
      w_sresp  = faulty(int'(sif.alu_op), int'(sif.dat_a), int'(sif.dat_b), int'(sif.sc_in), 1);
      sif.rslt = w_sresp[10:3];
      sif.zero = w_sresp[2];
      sif.par  = w_sresp[1];
      sif.sco  = w_sresp[0];
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic bit vec_fails(input vec_t v, input int mode);
      logic [10:0] g;
      logic [10:0] f;
      g = golden(v.op, v.a, v.b, v.sc);
      f = faulty(v.op, v.a, v.b, v.sc, mode);
      if (g[10:1] != f[10:1]) return 1'b1;
      return ((v.op == 0) || (v.op == 1) || (v.op == 5)) && (g[0] != f[0]);
   endfunction

   task automatic model_run(input int vpo, input int mode, input int s_edge, input bit push, output sum_t s);
      int   lfsr;
      int   fbit;
      int   ca[4];
      int   cb[4];
      vec_t v;
      ca = '{0, 255, 128, 255};
      cb = '{0, 1, 128, 255};
      lfsr = 'hACE1;
      s.start_edge = s_edge;
      s.done_edge  = s_edge + 2 + 2 * 7 * (4 + vpo);
      s.fails = 0; s.fop = 0; s.fa = 0; s.fb = 0;
      for (int op = 0; op < 7; op++) begin
         for (int k = 0; k < 4 + vpo; k++) begin
            v.op = op;
            if (k < 4) begin
               v.a = ca[k]; v.b = cb[k]; v.sc = 0;
            end else begin
               v.a  = lfsr / 256;
               v.b  = lfsr % 256;
               v.sc = (lfsr % 2) ^ (lfsr / 32768);
               fbit = ((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1;
               lfsr = ((lfsr << 1) | fbit) & 'hFFFF;
            end
            if (push) exp_vec_q.push_back(v);
            if (vec_fails(v, mode)) begin
               if (s.fails == 0) begin s.fop = op; s.fa = v.a; s.fb = v.b; end
               if (s.fails < 255) s.fails++;
            end
         end
      end
   endtask

   // Monitor: pops the expected vector stream and the end-of-run summary
   logic prev_done = 1'b0;
   always @(posedge clk) begin : monitor
      int   off;
      int   doff;
      vec_t v;
      sum_t s;
      #1;
      if (exp_sum_q.size() > 0) begin
         off  = cyc - exp_sum_q[0].start_edge;
         doff = exp_sum_q[0].done_edge - exp_sum_q[0].start_edge;
         if (off == 0) chk("busy_before_seed", busy, 1'b0);
         if (off == 1) chk("busy_rise", busy, 1'b1);
         if (off >= 2 && (off % 2) == 0 && off <= doff - 2 && exp_vec_q.size() > 0) begin
            v = exp_vec_q.pop_front();
            chk("vector", {aif.alu_op, aif.dat_a, aif.dat_b, aif.sc_in},
                {v.op[2:0], v.a[7:0], v.b[7:0], v.sc[0]});
         end
         if (done && !prev_done) begin
            s = exp_sum_q.pop_front();
            chk("done_edge", cyc, s.done_edge);
            chk("busy_at_done", busy, 1'b0);
            chk("fail_count", fail_count, s.fails);
            chk("fail_op", fail_op, s.fop);
            chk("fail_a", fail_a, s.fa);
            chk("fail_b", fail_b, s.fb);
            chk("pass", pass, (s.fails == 0));
            chk("vectors_left", exp_vec_q.size(), 0);
         end
      end else if (done && !prev_done) begin
         chk("unexpected_done", 1'b1, 1'b0);
      end
      prev_done <= done;
   end

   task automatic pulse_start(input int mode, input bit expect_run);
      sum_t s;
      @(negedge clk);
      if (expect_run) begin
         fault_mode = mode;
         model_run(VPO, mode, cyc + 1, 1'b1, s);
         exp_sum_q.push_back(s);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (exp_sum_q.size() > 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("run_completes", exp_sum_q.size(), 0);
      exp_sum_q.delete();
      exp_vec_q.delete();
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {busy, done, pass, fail_count, fail_op, fail_a, fail_b,
                 aif.dat_a, aif.dat_b, aif.alu_op, aif.sc_in}, 64'd0);
   endtask

   initial begin : stim
      int   modes[5];
      int   j, t, s0, n;
      sum_t ss;
      modes = '{1, 2, 3, 4, 5};
      rst_n = 1'b0; start = 1'b0; start_sat = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset_outputs");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      pulse_start(0, 1'b1);
      wait_done(400);

      for (int i = 4; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = modes[i]; modes[i] = modes[j]; modes[j] = t;
      end
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(5, 0)) @(negedge clk);
         pulse_start(modes[i], 1'b1);
         wait_done(400);
         if (modes[i] == 1) begin
            chk("par_inv_count", fail_count, 8'h8C);
            chk("par_inv_first", {fail_op, fail_a, fail_b}, {3'd0, 8'h00, 8'h00});
         end else if (modes[i] == 2) begin
            chk("and_first", {fail_op, fail_a, fail_b}, {3'd2, 8'hFF, 8'h01});
            chk("and_seen", (fail_count >= 8'd1), 1'b1);
         end else if (modes[i] == 3) begin
            chk("zero_first", {fail_op, fail_a, fail_b}, {3'd0, 8'h00, 8'h00});
         end else if (modes[i] == 4) begin
            chk("sco_inv_count", fail_count, 8'h3C);
         end
      end

      pulse_start(0, 1'b1);
      repeat ($urandom_range(270, 3)) @(negedge clk);
      pulse_start(3, 1'b0);
      wait_done(400);

      pulse_start(1, 1'b1);
      wait_done(400);
      repeat ($urandom_range(6, 2)) @(negedge clk);
      chk("done_held", {done, fail_count}, {1'b1, 8'h8C});
      pulse_start(0, 1'b1);
      @(posedge clk); #1;
      chk("done_drops", done, 1'b0);
      @(posedge clk); #1;
      chk("fail_count_cleared", {busy, fail_count}, {1'b1, 8'h00});
      wait_done(400);

      pulse_start(2, 1'b1);
      s0 = cyc;
      while (cyc < s0 + 100) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      exp_sum_q.delete();
      exp_vec_q.delete();
      #1;
      chk_all_zero("midrun_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("idle_after_reset", {busy, done, fail_count}, 10'd0);
      pulse_start(1, 1'b1);
      wait_done(400);
      chk("fresh_count", fail_count, 8'h8C);

      @(negedge clk);
      model_run(VPO_SAT, 1, cyc + 1, 1'b0, ss);
      start_sat = 1'b1;
      @(negedge clk);
      start_sat = 1'b0;
      n = 0;
      while (!s_done && n < 800) begin
         @(posedge clk); #1;
         n++;
      end
      chk("sat_done_edge", cyc, ss.done_edge);
      chk("sat_count", s_fail_count, ss.fails);
      chk("sat_count_ff", s_fail_count, 8'hFF);
      chk("sat_first", {s_fail_op, s_fail_a, s_fail_b, s_pass}, {3'd0, 8'h00, 8'h00, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
